// File: rtl/par_a_serial_pkg.sv
// Shared constants for the parallel-to-serial link (transmitter and SaP receiver).
package par_a_serial_pkg;

    localparam int                 BYTE_W   = 8;
    localparam int                 CNT_W    = 3;
    localparam logic [BYTE_W-1:0]  COM_BYTE = 8'hBC;
    localparam logic [CNT_W-1:0]   CNT_LAST = 3'd7;

endpackage

// File: rtl/pas_retencion.sv
// One-entry holding register with valid/listo handshake; drained by the shifter at each frame boundary.
module pas_retencion
    import par_a_serial_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [BYTE_W-1:0] i_byte,
    input  logic              i_valid,
    input  logic              i_boundary,
    output logic [BYTE_W-1:0] o_hold,
    output logic              o_hold_v,
    output logic              o_listo
);

    logic [BYTE_W-1:0] r_hold;
    logic              r_hold_v;

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold   <= '0;
            r_hold_v <= 1'b0;
        end else if (i_boundary) begin
            // A full hold drains into the shifter; an empty one lets the byte bypass, so nothing is stored.
            r_hold_v <= 1'b0;
        end else if (i_valid && !r_hold_v) begin
            r_hold   <= i_byte;
            r_hold_v <= 1'b1;
        end
    end

    assign o_hold   = r_hold;
    assign o_hold_v = r_hold_v;
    assign o_listo  = !r_hold_v;

endmodule

// File: rtl/par_a_serial.sv
// Parallel-to-serial transmitter: MSB-first, 8 clocks per frame, idle frames fill gaps.
// Build option PAS_IDLE_COM_EN: idle frames carry IDLE_BYTE instead of 8'h00.
module par_a_serial
    import par_a_serial_pkg::*;
#(
    parameter logic [BYTE_W-1:0] IDLE_BYTE = COM_BYTE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BYTE_W-1:0] Entrada,
    input  logic              validEntrada,
    output logic              listo,
    output logic              Salida,
    output logic              validSalida,
    output logic              inicio_byte
);

`ifdef PAS_IDLE_COM_EN
    localparam bit IDLE_EN = 1'b1;
`else
    localparam bit IDLE_EN = 1'b0;
`endif
    localparam logic [BYTE_W-1:0] L_IDLE = IDLE_EN ? IDLE_BYTE : '0;

    logic [CNT_W-1:0]  r_cnt;
    logic [BYTE_W-1:0] r_sh;
    logic              r_sh_data;

    logic              w_boundary;
    logic [BYTE_W-1:0] w_hold;
    logic              w_hold_v;
    logic              w_listo;

    assign w_boundary = (r_cnt == CNT_LAST);

    pas_retencion u_retencion (
        .clk        (clk),
        .reset      (reset),
        .i_byte     (Entrada),
        .i_valid    (validEntrada),
        .i_boundary (w_boundary),
        .o_hold     (w_hold),
        .o_hold_v   (w_hold_v),
        .o_listo    (w_listo)
    );

    // Counter wraps 7->0 on its own; frame loads priority: held byte, bypassed byte, idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_sh      <= L_IDLE;
            r_sh_data <= 1'b0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
            if (!w_boundary) begin
                r_sh <= {r_sh[BYTE_W-2:0], 1'b0};
            end else if (w_hold_v) begin
                r_sh      <= w_hold;
                r_sh_data <= 1'b1;
            end else if (validEntrada) begin
                r_sh      <= Entrada;
                r_sh_data <= 1'b1;
            end else begin
                r_sh      <= L_IDLE;
                r_sh_data <= 1'b0;
            end
        end
    end

    assign Salida      = r_sh[BYTE_W-1];
    assign validSalida = r_sh_data;
    assign inicio_byte = (r_cnt == '0);
    assign listo       = w_listo;

endmodule

// File: tb/tb_par_a_serial.sv
// Self-checking bench for par_a_serial: directed scenarios plus a byte scoreboard on the serial output.
module tb_par_a_serial;

`ifdef PAS_IDLE_COM_EN
    localparam logic [7:0] IDLE_REF = 8'hBC;
`else
    localparam logic [7:0] IDLE_REF = 8'h00;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] Entrada = 8'h00;
    logic       validEntrada = 1'b0;
    logic       listo;
    logic       Salida;
    logic       validSalida;
    logic       inicio_byte;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] idle_v  = IDLE_REF;
    logic [7:0] sb_q[$];
    logic [2:0] tcnt;

    par_a_serial dut (
        .clk          (clk),
        .reset        (reset),
        .Entrada      (Entrada),
        .validEntrada (validEntrada),
        .listo        (listo),
        .Salida       (Salida),
        .validSalida  (validSalida),
        .inicio_byte  (inicio_byte)
    );

    always #5 clk = ~clk;

    // Reference frame phase: counts clocks since reset release.
    always @(posedge clk or posedge reset) begin
        if (reset) tcnt <= 3'd0;
        else       tcnt <= tcnt + 3'd1;
    end

    // Output monitor and scoreboard, sampled on the falling edge.
    initial begin : monitor
        logic [7:0] f_bits;
        logic [7:0] exp_b;
        int         f_nvalid;
        bit         f_started;
        f_bits = '0; f_nvalid = 0; f_started = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                sb_q.delete();
                f_started = 0;
            end else begin
                n_tests++;
                if (inicio_byte !== (tcnt == 3'd0)) begin
                    n_fail++;
                    $display("FAIL inicio_phase: got %b expected %b at phase %0d", inicio_byte, (tcnt == 3'd0), tcnt);
                end
                if (tcnt == 3'd0) begin
                    f_bits = '0; f_nvalid = 0; f_started = 1;
                end
                f_bits = {f_bits[6:0], Salida};
                if (validSalida) f_nvalid++;
                if (tcnt == 3'd7 && f_started) begin
                    n_tests++;
                    if (f_nvalid == 0) begin
                        if (f_bits !== IDLE_REF) begin
                            n_fail++;
                            $display("FAIL idle_frame: got %h expected %h", f_bits, IDLE_REF);
                        end
                    end else if (f_nvalid == 8) begin
                        if (sb_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL unexpected_data: got %h expected no data frame", f_bits);
                        end else begin
                            exp_b = sb_q.pop_front();
                            if (f_bits !== exp_b) begin
                                n_fail++;
                                $display("FAIL data_frame: got %h expected %h", f_bits, exp_b);
                            end
                        end
                    end else begin
                        n_fail++;
                        $display("FAIL valid_mixed: got %0d valid bits expected 0 or 8", f_nvalid);
                    end
                end
                if (validEntrada && listo) sb_q.push_back(Entrada);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tcnt(input logic [2:0] p);
        int k = 0;
        while (tcnt != p && k < 16) begin
            tick();
            k++;
        end
        n_tests++;
        if (tcnt != p) begin
            n_fail++;
            $display("FAIL wait_phase: got %0d expected %0d", tcnt, p);
        end
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #2;
        for (int r = 0; r < 2; r++) begin
            n_tests++;
            if ({listo, validSalida, inicio_byte, Salida} !== {1'b1, 1'b0, 1'b1, idle_v[7]}) begin
                n_fail++;
                $display("FAIL reset_outputs: got %b expected %b", {listo, validSalida, inicio_byte, Salida},
                         {1'b1, 1'b0, 1'b1, idle_v[7]});
            end
            tick();
        end
        #2 reset = 1'b0;
    endtask

    task automatic test_idle();
        wait_tcnt(3'd0);
        for (int i = 0; i < 16; i++) begin
            n_tests++;
            if ({Salida, validSalida, listo} !== {idle_v[7 - (i % 8)], 1'b0, 1'b1}) begin
                n_fail++;
                $display("FAIL idle_bits: got %b expected %b at cycle %0d", {Salida, validSalida, listo},
                         {idle_v[7 - (i % 8)], 1'b0, 1'b1}, i);
            end
            tick();
        end
    endtask

    task automatic test_bypass();
        logic [7:0] bb = 8'hA5;
        wait_tcnt(3'd7);
        Entrada = bb;
        validEntrada = 1'b1;
        n_tests++;
        if (listo !== 1'b1) begin
            n_fail++;
            $display("FAIL bypass_listo: got %b expected 1", listo);
        end
        tick();
        validEntrada = 1'b0;
        Entrada = 8'h00;
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if ({Salida, validSalida, inicio_byte} !== {bb[7 - i], 1'b1, (i == 0)}) begin
                n_fail++;
                $display("FAIL bypass_bit: got %b expected %b at bit %0d", {Salida, validSalida, inicio_byte},
                         {bb[7 - i], 1'b1, (i == 0)}, i);
            end
            tick();
        end
        n_tests++;
        if ({Salida, validSalida} !== {idle_v[7], 1'b0}) begin
            n_fail++;
            $display("FAIL bypass_idle_resume: got %b expected %b", {Salida, validSalida}, {idle_v[7], 1'b0});
        end
    endtask

    task automatic b2b_tick(inout int vcnt, inout int rises, inout bit prev);
        tick();
        if (validSalida) vcnt++;
        if (validSalida && !prev) rises++;
        prev = validSalida;
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes_q[$] = '{8'h01, 8'hFF, 8'h3C};
        int  vcnt = 0, rises = 0, k;
        bit  prev = 0, acc, l;
        logic [2:0] pre;
        wait_tcnt(3'd2);
        foreach (bytes_q[j]) begin
            Entrada = bytes_q[j];
            validEntrada = 1'b1;
            acc = 0; k = 0; pre = 3'd0;
            while (!acc && k < 20) begin
                l = listo;
                pre = tcnt;
                b2b_tick(vcnt, rises, prev);
                k++;
                if (l) acc = 1;
            end
            n_tests++;
            if (!acc) begin
                n_fail++;
                $display("FAIL b2b_accept: got no transfer expected byte %h taken", bytes_q[j]);
            end else if (pre != 3'd7 && listo !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_listo_drop: got %b expected 0 after byte %h", listo, bytes_q[j]);
            end
        end
        validEntrada = 1'b0;
        k = 0;
        while (!(rises > 0 && !validSalida) && k < 60) begin
            b2b_tick(vcnt, rises, prev);
            k++;
        end
        n_tests++;
        if (vcnt !== 24 || rises !== 1) begin
            n_fail++;
            $display("FAIL b2b_contiguous: got %0d data cycles in %0d runs expected 24 in 1", vcnt, rises);
        end
    endtask

    task automatic test_hold_full();
        logic [7:0] yb = 8'h96;
        logic [7:0] got = '0;
        logic [2:0] pre = 3'd0;
        int  k = 0;
        bit  acc = 0, l;
        wait_tcnt(3'd3);
        Entrada = 8'h5A;
        validEntrada = 1'b1;
        tick();
        Entrada = yb;
        while (!acc && k < 20) begin
            l = listo;
            pre = tcnt;
            if (tcnt == 3'd7) begin
                n_tests++;
                if (listo !== 1'b0) begin
                    n_fail++;
                    $display("FAIL hold_full_listo: got %b expected 0 at boundary", listo);
                end
            end
            tick();
            k++;
            if (l) acc = 1;
        end
        validEntrada = 1'b0;
        n_tests++;
        if (!acc || pre != 3'd0) begin
            n_fail++;
            $display("FAIL hold_full_transfer: got accepted=%b at phase %0d expected accepted=1 at phase 0", acc, pre);
        end
        wait_tcnt(3'd0);
        for (int i = 0; i < 8; i++) begin
            got = {got[6:0], Salida};
            tick();
        end
        n_tests++;
        if (got !== yb) begin
            n_fail++;
            $display("FAIL hold_full_frame: got %h expected %h", got, yb);
        end
    endtask

    task automatic test_reset_mid();
        wait_tcnt(3'd7);
        Entrada = 8'hC3;
        validEntrada = 1'b1;
        tick();
        validEntrada = 1'b0;
        tick();
        Entrada = 8'h77;
        validEntrada = 1'b1;
        tick();
        validEntrada = 1'b0;
        n_tests++;
        if (listo !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_hold_full: got %b expected 0", listo);
        end
        tick();
        n_tests++;
        if (validSalida !== 1'b1 || tcnt != 3'd3) begin
            n_fail++;
            $display("FAIL mid_in_flight: got valid=%b phase=%0d expected valid=1 phase=3", validSalida, tcnt);
        end
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if ({listo, validSalida, inicio_byte, Salida} !== {1'b1, 1'b0, 1'b1, idle_v[7]}) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got %b expected %b", {listo, validSalida, inicio_byte, Salida},
                     {1'b1, 1'b0, 1'b1, idle_v[7]});
        end
        tick();
        tick();
        #2 reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            n_tests++;
            if ({validSalida, inicio_byte} !== {1'b0, (i % 8 == 0)}) begin
                n_fail++;
                $display("FAIL mid_after_release: got %b expected %b at cycle %0d", {validSalida, inicio_byte},
                         {1'b0, (i % 8 == 0)}, i);
            end
            tick();
        end
    endtask

    task automatic test_drain();
        repeat (16) tick();
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_scoreboard: got %0d pending bytes expected 0", sb_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_bypass();
        test_back_to_back();
        test_hold_full();
        test_reset_mid();
        test_drain();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
